// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin conditioning, frame deframing and checking,
// and a small receive FIFO popped by the keyboard bus wrapper.
module ps2_rx_fifo #(
    parameter int DEPTH_LOG2     = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk_cpu,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rdn,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    // Bit 0 carries the clock pin, bit 1 the data pin.
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    filt_q, filt_d;
    logic [FW-1:0] fcnt_q [2];
    logic [FW-1:0] fcnt_d [2];
    logic          fall_q, fall_d;

    state_t        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          push;

    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  pop, full, do_push;

    // A filtered pin only follows the synchronised pin after FILTER_LEN
    // consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FW'(1);
                end
            end
        end
        fall_d = filt_q[0] & ~filt_d[0];
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        tmo_d    = '0;
        err_d    = 1'b0;
        push     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall_q && !filt_q[1]) begin
                    state_d  = RECV;
                    bitcnt_d = 4'd1;
                end
            end
            RECV: begin
                if (fall_q) begin
                    if (bitcnt_q == 4'd10) begin
                        state_d  = IDLE;
                        bitcnt_d = 4'd0;
                        // shift_q holds data+parity; filt_q[1] is the stop bit.
                        if (^shift_q && filt_q[1]) begin
                            push = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        shift_d  = {filt_q[1], shift_q[8:1]};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = IDLE;
                    bitcnt_d = 4'd0;
                    err_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop     = !rdn && (count_q != '0);
        full    = count_q[DEPTH_LOG2];
        do_push = push && (!full || pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (do_push) begin
            mem_d[wptr_q] = shift_q[7:0];
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (do_push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        if (pop) begin
            ovf_d = 1'b0;
        end else if (push && full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            filt_q   <= 2'b11;
            fcnt_q   <= '{default: '0};
            fall_q   <= 1'b0;
            state_q  <= IDLE;
            bitcnt_q <= 4'd0;
            shift_q  <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            mem_q    <= '{default: '0};
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= {ps2_data, ps2_clk};
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            fall_q   <= fall_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready     = (count_q != '0);
    assign data      = ready ? mem_q[rptr_q] : 8'h00;
    assign overflow  = ovf_q;
    assign frame_err = err_q;

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- PS/2 device-to-host receiver plus receive FIFO. Feeds the keyboard bus wrapper that sits downstream.
- Synchronises and filters the raw ps2_clk/ps2_data pins into the clk_cpu domain, then deframes 11-bit PS/2 frames and checks them.
- Valid scan-code bytes are queued in a small FIFO. The head byte, ready and overflow are exposed to the wrapper, which pops with an active-low read strobe.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries).
- FILTER_LEN, 4, consecutive identical synchronised samples required before a pin's filtered value changes.
- TIMEOUT_CYCLES, 5000, clk_cpu cycles without a filtered ps2_clk falling edge, mid-frame, before the frame is aborted.

Ports:
- clk_cpu  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data  in  1  raw PS/2 data pin (asynchronous).
- rdn  in  1  active-low pop request.
- data  out  8  FIFO head byte; valid only while ready=1.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse when a frame is rejected or aborted.

Behaviour:

Reset:
- Applies to all state: sync/filter registers set to 1, FSM to IDLE, bit counter 0, timeout counter 0, FIFO pointers and count 0.
- Outputs after reset: ready=0, overflow=0, frame_err=0, data=8'h00.
- Reset mid-frame discards the partial frame.

Input conditioning:
- 2-FF synchroniser on each pin, followed by a saturating filter of FILTER_LEN samples.
- A falling edge (fall) is filtered ps2_clk going 1->0, registered as a single-cycle pulse.
- Data is sampled from filtered ps2_data in the same cycle that fall is asserted.

FSM, states IDLE and RECV:
- IDLE: on fall with data=0 (start bit), go to RECV with bitcnt=1. On fall with data=1, stay in IDLE and do nothing.
- RECV, on each fall: shift the sampled bit into the frame register and increment bitcnt. Order is bits 1-8 data LSB first, bit 9 odd parity, bit 10 stop.
- RECV, 11th bit: on the fall with bitcnt=10, the frame is checked and the FSM returns to IDLE. The frame is valid when the parity bit makes the count of ones over data+parity odd AND stop=1.
  - Valid: push the data byte on that same edge.
  - Invalid: no push; frame_err=1 for the next cycle.
- RECV timeout: the counter resets on every fall. When it reaches TIMEOUT_CYCLES, go to IDLE, clear bitcnt, and pulse frame_err. No push.

FIFO:
- Circular buffer with DEPTH_LOG2-bit read/write pointers that wrap, and a (DEPTH_LOG2+1)-bit count.
- data is a combinational read of mem[rptr]. ready = (count != 0), registered via count.
- Pop occurs on an edge where rdn=0 and ready=1; rptr increments. rdn=0 while empty is ignored.
- Push when not full: write mem[wptr], increment wptr.
- Push when full with no pop: byte dropped, overflow set to 1.
- Simultaneous push and pop when full: both happen, count unchanged, no overflow.
- Simultaneous push and pop when count=0: push only (pop gated by ready).
- overflow stays 1 until reset or the next successful pop.

Latency:
- Pin edge to fall: 2 (sync) + FILTER_LEN cycles.
- ready rises the cycle after the push edge.
- data updates the cycle after a pop edge.

Test Plan:
- Send frame for 0x1C (start 0, data 00111000 LSB first, parity 0, stop 1), 10 kHz PS/2 clock, rdn=1 -> ready=1, data=8'h1C, frame_err never pulses. Then hold rdn=0 for one cycle -> ready=0 next cycle.
- Send 0xF0 then 0x1C, no reads -> data=F0. Pop -> data=1C. Pop -> ready=0. overflow=0 throughout.
- Send 9 valid bytes 0x01..0x09 with rdn=1 -> overflow=1 after the 9th frame. Popping 8 times yields 01..08; overflow=0 after the first pop; ready=0 after the 8th pop.
- Send 0x1C with parity bit 1, and separately 0x1C with stop bit 0 -> frame_err pulses exactly 1 cycle each time, ready stays 0.
- Send start + 4 data bits, then hold ps2_clk high beyond 5000 cycles -> frame_err pulse, FSM back in IDLE. Follow with a valid 0x5A frame -> data=8'h5A.
- Assert reset for 1 cycle in the middle of a frame with 2 bytes queued -> ready=0, overflow=0. Next full valid frame 0x29 -> data=8'h29.
- Hold 3-cycle glitches low on ps2_clk while idle -> no state change (FILTER_LEN=4).
